reg_writeback_ctrl: RTL
=======================

# reg_writeback_ctrl

Writeback controller that drives the write port of the CPU register file. It merges single-cycle ALU results with completions from long-latency units (load/store, multiply) into one registered write per cycle. Long-latency results are buffered in a small queue. A 32-bit scoreboard tells decode which destination registers still have writes in flight. It sits between execute/memory and the register file write port (`RegWrite`, `Rd`, `write_data`).

## Interface
- `DEPTH`, default 4: long-latency result queue entries (power of two, ≥2).
- `XLEN`, default 32: data width.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `alu_valid`  in  1  ALU result present this cycle; never back-pressured.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  XLEN  ALU result.
- `lu_valid`  in  1  long-latency result offered.
- `lu_ready`  out  1  queue can accept; transfer occurs when `lu_valid && lu_ready` at a rising edge.
- `lu_rd`  in  5  long-latency destination register.
- `lu_data`  in  XLEN  long-latency result.
- `issue_valid`  in  1  a long-latency op is issued this cycle.
- `issue_rd`  in  5  destination of the issued op.
- `RegWrite`  out  1  register-file write enable (registered).
- `Rd`  out  5  register-file write address (registered).
- `write_data`  out  XLEN  register-file write data (registered).
- `busy`  out  32  scoreboard: bit *r* = write to x*r* pending.
- `pend_count`  out  $clog2(DEPTH+1)  queue occupancy.

## Operation
- Each edge, the output register loads at most one write. Priority order:
  - `alu_valid` (ALU always wins).
  - Otherwise the queue head (pop).
  - Otherwise none: `RegWrite`=0; `Rd`/`write_data` hold their previous values.
- x0 writes are suppressed, from either source:
  - An ALU result with rd=0 is not output.
  - A queue entry with rd=0 is popped but produces `RegWrite`=0.
  - In both cases `RegWrite` is never 1 with `Rd`=0.
- `lu_ready` = (`pend_count` < `DEPTH`). It depends on state only, with no combinational path from `lu_valid`.
- Queue push and pop in the same edge: `pend_count` is unchanged. Queue order is strict FIFO.
- Scoreboard:
  - `issue_valid` with `issue_rd`≠0 sets `busy[issue_rd]`.
  - Popping an entry clears `busy[rd]`.
  - Set and clear of the same bit at the same edge: set wins.
  - `busy[0]` is always 0.
  - ALU writes do not touch `busy`.
- No starvation guard. A continuous `alu_valid` stream holds the queue, and `lu_ready` falls once the queue is full.
- Reset values:
  - `RegWrite`=0, `Rd`=0, `write_data`=0.
  - `busy`=0, `pend_count`=0, `lu_ready`=1.
  - Queue pointers are 0.
- Reset mid-operation discards all queued entries and pending scoreboard bits. No write is emitted for them.

## Timing
- ALU path: `alu_valid` sampled at edge E, `RegWrite` high during cycle E→E+1, register file updated at edge E+1. Latency 1.
- Long-latency path: accepted at edge E, earliest pop at edge E+1, `RegWrite` high after E+1. Minimum latency 2; there is no empty-queue bypass.
- `busy` bit set at edge E (issue) and cleared at the pop edge. It is visible to decode in the same cycle as the write output.
- Full queue: `lu_ready`=0 for the whole cycle. It rises in the cycle after a pop.
- Pointers wrap modulo `DEPTH`. Occupancy uses a separate counter, so full and empty are unambiguous.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN`.
  - `REG_ADDR_W`=5.
  - `NUM_REGS`=32.
  - Typedef `wb_entry_t` {rd[4:0], data[XLEN-1:0]}.
- Sub-module `wb_fifo`: synchronous FIFO of `wb_entry_t`, `DEPTH` entries. It provides push/pop/full/empty/count and uses the same async active-high reset.
- The top level contains the priority mux, x0 suppression, output register and scoreboard.

## Test plan
- After reset: `RegWrite`=0, `busy`=0, `lu_ready`=1, `pend_count`=0. Then ALU x5=0x1234 at edge 1 → `RegWrite`=1, `Rd`=5, `write_data`=0x1234 in the following cycle only.
- Issue x7, then LU x7=0xDEAD accepted at edge 3 with no ALU traffic → `busy[7]`=1 until pop at edge 4. The write appears after edge 4 and `busy[7]`=0 from that edge.
- ALU valid every cycle while 5 LU results are offered → 4 accepted, `lu_ready`=0, `pend_count`=4. After ALU stops, 4 writes drain in FIFO order on consecutive cycles.
- Same edge: ALU x3=1 and a queued LU x9=2 → x3 written first, x9 the next cycle. Separately, issue x9 at the same edge as x9's pop → `busy[9]` remains 1.
- ALU rd=0 and LU rd=0 → neither asserts `RegWrite`. The LU entry is still popped and `pend_count` decrements.
- Queue holding 3 entries, reset asserted asynchronously mid-cycle → outputs and `busy` go to 0 immediately. No queued write ever appears after reset release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared CPU definitions: data width, register-file geometry and the
// writeback entry carried by long-latency completions.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries. Occupancy is tracked with its own
// counter so full and empty are unambiguous when the pointers wrap.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  wb_entry_t                  push_entry,
  input  logic                       pop,
  output wb_entry_t                  head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  wb_entry_t        mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (count_r == DEPTH_C);
  assign empty  = (count_r == {CNT_W{1'b0}});
  assign count  = count_r;
  assign head   = mem_r[rd_ptr_r];
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;

  // Entry storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_entry;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-file writeback controller: ALU results win over queued
// long-latency completions; x0 writes are dropped; a scoreboard tracks pending rd.
module reg_writeback_ctrl
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = riscv_pkg::XLEN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  input  logic [4:0]                 alu_rd,
  input  logic [XLEN-1:0]            alu_data,
  input  logic                       lu_valid,
  output logic                       lu_ready,
  input  logic [4:0]                 lu_rd,
  input  logic [XLEN-1:0]            lu_data,
  input  logic                       issue_valid,
  input  logic [4:0]                 issue_rd,
  output logic                       RegWrite,
  output logic [4:0]                 Rd,
  output logic [XLEN-1:0]            write_data,
  output logic [31:0]                busy,
  output logic [$clog2(DEPTH+1)-1:0] pend_count
);

  wb_entry_t   push_entry_s;
  wb_entry_t   head_s;
  logic        full_s;
  logic        empty_s;
  logic        push_s;
  logic        pop_s;
  logic        wr_en_s;
  logic [4:0]  wr_rd_s;
  logic [XLEN-1:0] wr_data_s;
  logic [31:0] busy_next_s;
  logic        regwrite_r;
  logic [4:0]  rd_r;
  logic [XLEN-1:0] wdata_r;
  logic [31:0] busy_r;

  // lu_ready comes from queue state only, never from lu_valid.
  assign lu_ready          = !full_s;
  assign push_s            = lu_valid && !full_s;
  assign pop_s             = !alu_valid && !empty_s;
  assign push_entry_s.rd   = lu_rd;
  assign push_entry_s.data = lu_data;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .head       (head_s),
    .full       (full_s),
    .empty      (empty_s),
    .count      (pend_count)
  );

  // Source select and x0 suppression for the next register-file write.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_rd_s   = 5'd0;
    wr_data_s = {XLEN{1'b0}};
    if (alu_valid) begin
      wr_en_s   = (alu_rd != 5'd0);
      wr_rd_s   = alu_rd;
      wr_data_s = alu_data;
    end else if (!empty_s) begin
      wr_en_s   = (head_s.rd != 5'd0);
      wr_rd_s   = head_s.rd;
      wr_data_s = head_s.data;
    end else begin
      wr_en_s   = 1'b0;
    end
  end

  // Scoreboard update: clear on pop first so a same-edge issue wins.
  always_comb begin
    busy_next_s = busy_r;
    if (pop_s) begin
      busy_next_s[head_s.rd] = 1'b0;
    end else begin
      busy_next_s = busy_r;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      busy_next_s[issue_rd] = 1'b1;
    end else begin
      busy_next_s[0] = 1'b0;
    end
    busy_next_s[0] = 1'b0;
  end

  // Registered write port; address and data hold when nothing is written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regwrite_r <= 1'b0;
      rd_r       <= 5'd0;
      wdata_r    <= {XLEN{1'b0}};
      busy_r     <= 32'd0;
    end else begin
      regwrite_r <= wr_en_s;
      busy_r     <= busy_next_s;
      if (wr_en_s) begin
        rd_r    <= wr_rd_s;
        wdata_r <= wr_data_s;
      end
    end
  end

  assign RegWrite   = regwrite_r;
  assign Rd         = rd_r;
  assign write_data = wdata_r;
  assign busy       = busy_r;

endmodule
